// File: rtl/riscv_pkg.sv
// ============================================================================
// Module      : riscv_pkg
// Description : Shared trap-cause type and synchronous-exception priority encoder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package riscv_pkg;

  typedef logic [19:0] trap_cause_t;

  // Returns the highest-priority raised code. Later tests override earlier ones,
  // so the chain reads from lowest to highest priority.
  function automatic logic [4:0] transform_cause(input trap_cause_t cause);
    logic [4:0] code;
    code = 5'd0;
    if (cause[5])  code = 5'd5;
    if (cause[7])  code = 5'd7;
    if (cause[13]) code = 5'd13;
    if (cause[15]) code = 5'd15;
    if (cause[4])  code = 5'd4;
    if (cause[6])  code = 5'd6;
    if (cause[11]) code = 5'd11;
    if (cause[9])  code = 5'd9;
    if (cause[8])  code = 5'd8;
    if (cause[0])  code = 5'd0;
    if (cause[2])  code = 5'd2;
    if (cause[1])  code = 5'd1;
    if (cause[12]) code = 5'd12;
    if (cause[3])  code = 5'd3;
    return code;
  endfunction

endpackage

`default_nettype wire

// File: rtl/trap_unit.sv
// ============================================================================
// Module      : trap_unit
// Description : M-mode trap controller: trap/mret entry, fetch redirect, trap CSRs.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module trap_unit
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmt_valid,
  output logic              cmt_ready,
  input  logic [XLEN-1:0]   cmt_pc,
  input  trap_cause_t       cmt_cause,
  input  logic [XLEN-1:0]   cmt_tval,
  input  logic              cmt_mret,
  input  logic              irq_msi,
  input  logic              irq_mti,
  input  logic              irq_mei,
  input  logic              csr_we,
  input  logic [11:0]       csr_addr,
  input  logic [XLEN-1:0]   csr_wdata,
  output logic [XLEN-1:0]   csr_rdata,
  output logic              flush,
  output logic              redirect_valid,
  input  logic              redirect_ready,
  output logic [XLEN-1:0]   redirect_pc,
  output logic [1:0]        priv
);

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MIE     = 12'h304;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MTVAL   = 12'h343;
  localparam logic [11:0] CSR_MIP     = 12'h344;

  localparam logic [1:0] PRIV_M = 2'b11;
  localparam logic [1:0] PRIV_U = 2'b00;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_REDIR = 1'b1
  } state_e;

  state_e            state_q;
  logic              st_mie_q;
  logic              st_mpie_q;
  logic [1:0]        st_mpp_q;
  logic [2:0]        mie_q;        // {MEIE, MTIE, MSIE}
  logic [XLEN-1:0]   mtvec_q;
  logic [XLEN-1:0]   mepc_q;
  logic [XLEN-1:0]   mcause_q;
  logic [XLEN-1:0]   mtval_q;
  logic [1:0]        priv_q;
  logic              flush_q;
  logic              redir_valid_q;
  logic [XLEN-1:0]   redir_pc_q;

  logic [XLEN-1:0]   mie_val;
  logic [XLEN-1:0]   mip_val;
  logic [XLEN-1:0]   mstatus_val;
  logic [XLEN-1:0]   irq_pend;
  logic [XLEN-1:0]   mtvec_base;
  logic [XLEN-1:0]   trap_pc;
  logic [4:0]        int_code;
  logic [4:0]        trap_code;
  logic              accept;
  logic              int_en;
  logic              take_int;
  logic              take_exc;
  logic              take_trap;
  logic              take_mret;
  logic              csr_wr;

  always_comb begin
    mie_val      = '0;
    mie_val[3]   = mie_q[0];
    mie_val[7]   = mie_q[1];
    mie_val[11]  = mie_q[2];
    mip_val      = '0;
    mip_val[3]   = irq_msi;
    mip_val[7]   = irq_mti;
    mip_val[11]  = irq_mei;
    mstatus_val        = '0;
    mstatus_val[3]     = st_mie_q;
    mstatus_val[7]     = st_mpie_q;
    mstatus_val[12:11] = st_mpp_q;
  end

  assign irq_pend  = mie_val & mip_val;
  assign accept    = (state_q == ST_IDLE) && cmt_valid;
  assign int_en    = (priv_q == PRIV_U) || st_mie_q;
  assign take_int  = accept && (|irq_pend) && int_en;
  assign take_exc  = accept && !take_int && (|cmt_cause);
  assign take_trap = take_int || take_exc;
  assign take_mret = accept && !take_trap && cmt_mret;
  // A write colliding with trap/mret entry would race the hardware update; drop it.
  assign csr_wr    = csr_we && !(take_trap || take_mret);

  assign int_code   = irq_pend[11] ? 5'd11 : (irq_pend[3] ? 5'd3 : 5'd7);
  assign trap_code  = take_int ? int_code : transform_cause(cmt_cause);
  assign mtvec_base = {mtvec_q[XLEN-1:2], 2'b00};
  assign trap_pc    = (take_int && (mtvec_q[1:0] == 2'b01))
                    ? mtvec_base + {{(XLEN-7){1'b0}}, trap_code, 2'b00}
                    : mtvec_base;

  always_comb begin
    csr_rdata = '0;
    case (csr_addr)
      CSR_MSTATUS: csr_rdata = mstatus_val;
      CSR_MIE:     csr_rdata = mie_val;
      CSR_MTVEC:   csr_rdata = mtvec_q;
      CSR_MEPC:    csr_rdata = mepc_q;
      CSR_MCAUSE:  csr_rdata = mcause_q;
      CSR_MTVAL:   csr_rdata = mtval_q;
      CSR_MIP:     csr_rdata = mip_val;
      default:     csr_rdata = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      st_mie_q      <= 1'b0;
      st_mpie_q     <= 1'b0;
      st_mpp_q      <= PRIV_M;
      mie_q         <= '0;
      mtvec_q       <= '0;
      mepc_q        <= '0;
      mcause_q      <= '0;
      mtval_q       <= '0;
      priv_q        <= PRIV_M;
      flush_q       <= 1'b0;
      redir_valid_q <= 1'b0;
      redir_pc_q    <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (take_trap || take_mret) begin
            state_q       <= ST_REDIR;
            flush_q       <= 1'b1;
            redir_valid_q <= 1'b1;
            redir_pc_q    <= take_trap ? trap_pc : mepc_q;
          end
        end
        ST_REDIR: begin
          if (redirect_ready) begin
            state_q       <= ST_IDLE;
            flush_q       <= 1'b0;
            redir_valid_q <= 1'b0;
          end
        end
        default: state_q <= ST_IDLE;
      endcase

      if (take_trap) begin
        mepc_q    <= cmt_pc;
        mcause_q  <= {take_int, {(XLEN-6){1'b0}}, trap_code};
        mtval_q   <= take_int ? '0 : cmt_tval;
        st_mpie_q <= st_mie_q;
        st_mie_q  <= 1'b0;
        st_mpp_q  <= priv_q;
        priv_q    <= PRIV_M;
      end else if (take_mret) begin
        priv_q    <= st_mpp_q;
        st_mie_q  <= st_mpie_q;
        st_mpie_q <= 1'b1;
        st_mpp_q  <= PRIV_U;
      end else if (csr_wr) begin
        case (csr_addr)
          CSR_MSTATUS: begin
            st_mie_q  <= csr_wdata[3];
            st_mpie_q <= csr_wdata[7];
            // Only M and U exist; reserved MPP encodings leave the field alone.
            if ((csr_wdata[12:11] == PRIV_M) || (csr_wdata[12:11] == PRIV_U))
              st_mpp_q <= csr_wdata[12:11];
          end
          CSR_MIE:    mie_q   <= {csr_wdata[11], csr_wdata[7], csr_wdata[3]};
          CSR_MTVEC:  mtvec_q <= {csr_wdata[XLEN-1:2], csr_wdata[1] ? 2'b00 : csr_wdata[1:0]};
          CSR_MEPC:   mepc_q  <= {csr_wdata[XLEN-1:2], 2'b00};
          CSR_MCAUSE: mcause_q <= csr_wdata;
          CSR_MTVAL:  mtval_q  <= csr_wdata;
          default: ;
        endcase
      end
    end
  end

  assign cmt_ready      = (state_q == ST_IDLE);
  assign flush          = flush_q;
  assign redirect_valid = redir_valid_q;
  assign redirect_pc    = redir_pc_q;
  assign priv           = priv_q;

endmodule

`default_nettype wire

// File: tb/tb_trap_unit.sv
// ============================================================================
// Module      : tb_trap_unit
// Description : Scoreboard bench for trap_unit against an architectural model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_trap_unit;

  localparam int XLEN = 32;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              cmt_valid = 1'b0;
  logic              cmt_ready;
  logic [XLEN-1:0]   cmt_pc = '0;
  logic [19:0]       cmt_cause = '0;
  logic [XLEN-1:0]   cmt_tval = '0;
  logic              cmt_mret = 1'b0;
  logic              irq_msi = 1'b0;
  logic              irq_mti = 1'b0;
  logic              irq_mei = 1'b0;
  logic              csr_we = 1'b0;
  logic [11:0]       csr_addr = '0;
  logic [XLEN-1:0]   csr_wdata = '0;
  logic [XLEN-1:0]   csr_rdata;
  logic              flush;
  logic              redirect_valid;
  logic              redirect_ready = 1'b0;
  logic [XLEN-1:0]   redirect_pc;
  logic [1:0]        priv;

  always #5 clk = ~clk;

  trap_unit #(.XLEN(XLEN)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmt_valid(cmt_valid), .cmt_ready(cmt_ready), .cmt_pc(cmt_pc),
    .cmt_cause(cmt_cause), .cmt_tval(cmt_tval), .cmt_mret(cmt_mret),
    .irq_msi(irq_msi), .irq_mti(irq_mti), .irq_mei(irq_mei),
    .csr_we(csr_we), .csr_addr(csr_addr), .csr_wdata(csr_wdata), .csr_rdata(csr_rdata),
    .flush(flush), .redirect_valid(redirect_valid), .redirect_ready(redirect_ready),
    .redirect_pc(redirect_pc), .priv(priv)
  );

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [31:0] pc;
    logic [1:0]  priv;
  } exp_t;
  exp_t exp_q[$];

  // Architectural model state
  bit        m_mie, m_mpie;
  bit [1:0]  m_mpp, m_priv;
  bit [31:0] m_mie_reg, m_mtvec, m_mepc, m_mcause, m_mtval;

  int PRIO [14] = '{3, 12, 1, 2, 0, 8, 9, 11, 6, 4, 15, 13, 7, 5};
  int IRQ_ORDER [3] = '{11, 3, 7};
  logic [11:0] CSR_LIST [8] = '{12'h300, 12'h304, 12'h305, 12'h341,
                                12'h342, 12'h343, 12'h344, 12'h340};
  int UNLISTED [6] = '{10, 14, 16, 17, 18, 19};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_mie = 0; m_mpie = 0; m_mpp = 2'b11; m_priv = 2'b11;
    m_mie_reg = 0; m_mtvec = 0; m_mepc = 0; m_mcause = 0; m_mtval = 0;
  endtask

  function automatic bit [31:0] model_read(input logic [11:0] a);
    case (a)
      12'h300: return (32'(m_mie) << 3) | (32'(m_mpie) << 7) | (32'(m_mpp) << 11);
      12'h304: return m_mie_reg;
      12'h305: return m_mtvec;
      12'h341: return m_mepc;
      12'h342: return m_mcause;
      12'h343: return m_mtval;
      12'h344: return (32'(irq_msi) << 3) | (32'(irq_mti) << 7) | (32'(irq_mei) << 11);
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_write(input logic [11:0] a, input logic [31:0] d);
    case (a)
      12'h300: begin
        m_mie = d[3]; m_mpie = d[7];
        if (d[12:11] == 2'b00 || d[12:11] == 2'b11) m_mpp = d[12:11];
      end
      12'h304: m_mie_reg = d & 32'h888;
      12'h305: m_mtvec = (d[1:0] >= 2) ? (d & ~32'h3) : d;
      12'h341: m_mepc = d & ~32'h3;
      12'h342: m_mcause = d;
      12'h343: m_mtval = d;
      default: ;
    endcase
  endtask

  task automatic csr_write(input logic [11:0] a, input logic [31:0] d);
    @(negedge clk);
    csr_we = 1'b1; csr_addr = a; csr_wdata = d;
    model_write(a, d);
    @(negedge clk);
    csr_we = 1'b0;
  endtask

  task automatic csr_check(input logic [11:0] a);
    @(negedge clk);
    csr_we = 1'b0; csr_addr = a;
    #1;
    check($sformatf("csr_%03h", a), csr_rdata, model_read(a));
  endtask

  task automatic csr_check_all();
    for (int i = 0; i < 8; i++) csr_check(CSR_LIST[i]);
    check("priv_idle", {30'd0, priv}, {30'd0, m_priv});
  endtask

  // hold < 0 means: assert reset in the middle of the redirect instead of completing it.
  task automatic do_commit(input logic [31:0] pc, input logic [19:0] cause,
                           input logic [31:0] tval, input bit mret, input bit [2:0] irq,
                           input bit we, input logic [11:0] waddr, input logic [31:0] wdata,
                           input int hold);
    bit        redir, intr, found;
    bit [31:0] mip, pend;
    int        code;
    exp_t      e;
    @(negedge clk);
    check("cmt_ready_idle", {31'd0, cmt_ready}, 32'd1);
    cmt_valid = 1'b1; cmt_pc = pc; cmt_cause = cause; cmt_tval = tval; cmt_mret = mret;
    irq_msi = irq[0]; irq_mti = irq[1]; irq_mei = irq[2];
    csr_we = we; csr_addr = waddr; csr_wdata = wdata;

    mip  = (32'(irq[0]) << 3) | (32'(irq[1]) << 7) | (32'(irq[2]) << 11);
    pend = m_mie_reg & mip;
    redir = 0; intr = 0; code = 0; found = 0;
    if (pend != 0 && (m_priv == 2'b00 || m_mie)) begin
      intr = 1;
      for (int i = 0; i < 3; i++)
        if (!found && pend[IRQ_ORDER[i]]) begin code = IRQ_ORDER[i]; found = 1; end
    end else if (cause != 0) begin
      for (int i = 0; i < 14; i++)
        if (!found && cause[PRIO[i]]) begin code = PRIO[i]; found = 1; end
    end
    if (intr || cause != 0) begin
      redir = 1;
      e.pc = {m_mtvec[31:2], 2'b00} + ((m_mtvec[1:0] == 2'b01 && intr) ? 32'(4 * code) : 32'd0);
      m_mepc = pc;
      m_mcause = (intr ? 32'h8000_0000 : 32'h0) | 32'(code);
      m_mtval = intr ? 32'h0 : tval;
      m_mpie = m_mie; m_mie = 0; m_mpp = m_priv; m_priv = 2'b11;
    end else if (mret) begin
      redir = 1;
      e.pc = m_mepc;
      m_priv = m_mpp; m_mie = m_mpie; m_mpie = 1; m_mpp = 2'b00;
    end else if (we) begin
      model_write(waddr, wdata);
    end
    if (redir) begin
      e.priv = m_priv;
      exp_q.push_back(e);
    end

    @(negedge clk);
    cmt_valid = 1'b0; cmt_cause = '0; cmt_mret = 1'b0;
    irq_msi = 1'b0; irq_mti = 1'b0; irq_mei = 1'b0; csr_we = 1'b0;
    if (redir && hold < 0) begin
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("rst_cmt_ready", {31'd0, cmt_ready}, 32'd1);
      check("rst_flush", {31'd0, flush}, 32'd0);
      check("rst_redirect_valid", {31'd0, redirect_valid}, 32'd0);
      check("rst_redirect_pc", redirect_pc, 32'd0);
      check("rst_priv", {30'd0, priv}, 32'd3);
      model_reset();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
    end else if (redir) begin
      redirect_ready = 1'b0;
      for (int i = 0; i < hold; i++) begin
        check("cmt_ready_redir", {31'd0, cmt_ready}, 32'd0);
        @(negedge clk);
      end
      redirect_ready = 1'b1;
      @(negedge clk);
      redirect_ready = 1'b0;
      check("cmt_ready_after", {31'd0, cmt_ready}, 32'd1);
    end
  endtask

  // Monitor: pops the scoreboard when a redirect appears, then watches it stay stable.
  bit          mon_active = 0;
  logic [31:0] mon_pc;
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (!rst_n) begin
      mon_active = 0;
    end else if (redirect_valid) begin
      if (!mon_active) begin
        mon_active = 1;
        mon_pc = redirect_pc;
        if (exp_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL unexpected_redirect: got pc 0x%08h, expected no redirect", redirect_pc);
        end else begin
          e = exp_q.pop_front();
          check("redirect_pc", redirect_pc, e.pc);
          check("redirect_priv", {30'd0, priv}, {30'd0, e.priv});
          check("flush", {31'd0, flush}, 32'd1);
        end
      end else begin
        check("redirect_pc_stable", redirect_pc, mon_pc);
        check("flush_held", {31'd0, flush}, 32'd1);
      end
    end else begin
      mon_active = 0;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [19:0] c;
    int          r;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    check("reset_cmt_ready", {31'd0, cmt_ready}, 32'd1);
    check("reset_flush", {31'd0, flush}, 32'd0);
    check("reset_redirect_valid", {31'd0, redirect_valid}, 32'd0);
    check("reset_redirect_pc", redirect_pc, 32'd0);
    check("reset_priv", {30'd0, priv}, 32'd3);
    @(negedge clk);
    rst_n = 1'b1;
    csr_check_all();

    // Illegal instruction
    csr_write(12'h305, 32'h8000_0000);
    do_commit(32'h100, 20'h4, 32'hDEAD, 0, 3'b000, 0, 12'h0, 32'h0, 1);
    csr_check_all();

    // Exception priority
    do_commit(32'h104, 20'h01004, 32'h1, 0, 3'b000, 0, 12'h0, 32'h0, 0);
    csr_check(12'h342);
    do_commit(32'h108, 20'h00110, 32'h2, 0, 3'b000, 0, 12'h0, 32'h0, 2);
    csr_check(12'h342);
    do_commit(32'h10C, 20'h10400, 32'h3, 0, 3'b000, 0, 12'h0, 32'h0, 0);
    csr_check(12'h342);

    // Vectored interrupts
    csr_write(12'h305, 32'h1001);
    csr_write(12'h304, 32'h80);
    csr_write(12'h300, 32'h1808);
    do_commit(32'h300, 20'h0, 32'h55, 0, 3'b010, 0, 12'h0, 32'h0, 1);
    csr_check_all();
    csr_write(12'h300, 32'h1808);
    csr_write(12'h304, 32'h880);
    do_commit(32'h304, 20'h4, 32'h66, 0, 3'b110, 0, 12'h0, 32'h0, 1);
    csr_check_all();

    // mret back to U, then an interrupt taken in U with MIE=0
    csr_write(12'h300, 32'h0080);
    csr_write(12'h341, 32'h200);
    do_commit(32'h400, 20'h0, 32'h0, 1, 3'b000, 0, 12'h0, 32'h0, 1);
    csr_check_all();
    csr_write(12'h300, 32'h0);
    csr_write(12'h304, 32'h8);
    do_commit(32'h204, 20'h0, 32'h0, 0, 3'b001, 0, 12'h0, 32'h0, 0);
    csr_check_all();

    // Redirect back-pressure, then reset during REDIR
    do_commit(32'h500, 20'h1, 32'h77, 0, 3'b000, 0, 12'h0, 32'h0, 5);
    do_commit(32'h504, 20'h2, 32'h88, 0, 3'b000, 0, 12'h0, 32'h0, -1);
    csr_check_all();

    // WARL and dropped writes
    csr_write(12'h305, 32'h103);
    csr_check(12'h305);
    csr_write(12'h341, 32'h207);
    csr_check(12'h341);
    csr_write(12'h300, 32'h0800);
    csr_check(12'h300);
    csr_write(12'h340, 32'hFFFF_FFFF);
    csr_check(12'h340);
    do_commit(32'h600, 20'h20, 32'h99, 0, 3'b000, 1, 12'h305, 32'h4000, 0);
    csr_check(12'h305);
    do_commit(32'h604, 20'h80, 32'hAA, 0, 3'b000, 1, 12'h343, 32'h1234, 0);
    csr_check(12'h343);
    do_commit(32'h608, 20'h0, 32'h0, 0, 3'b000, 1, 12'h343, 32'h1234, 0);
    csr_check(12'h343);

    // Randomized traffic
    for (int it = 0; it < 200; it++) begin
      r = $urandom_range(0, 9);
      if (r <= 2) begin
        csr_write(CSR_LIST[$urandom_range(0, 7)], $urandom);
      end else if (r == 3) begin
        csr_check_all();
      end else begin
        case ($urandom_range(0, 3))
          0: c = '0;
          1: c = 20'(1) << PRIO[$urandom_range(0, 13)];
          2: c = 20'($urandom);
          default: c = 20'(1) << UNLISTED[$urandom_range(0, 5)];
        endcase
        do_commit({$urandom, 2'b00} & 32'hFFFF_FFFC, c, $urandom,
                  ($urandom_range(0, 3) == 0), 3'($urandom_range(0, 7)),
                  ($urandom_range(0, 2) == 0), CSR_LIST[$urandom_range(0, 7)], $urandom,
                  $urandom_range(0, 3));
      end
    end
    csr_check_all();

    repeat (2) @(negedge clk);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
